// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding and default sizes.
package sram_ctrl_pkg;

  localparam int unsigned SramAddrW      = 18;
  localparam int unsigned SramDataW      = 16;
  localparam int unsigned SramAccCycles  = 2;
  localparam int unsigned SramInitCycles = 4;

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StIdle  = 3'd1,
    StData  = 3'd2,
    StFetch = 3'd3,
    StDone  = 3'd4
  } sram_state_e;

  // True in the states that drive an SRAM cycle.
  function automatic logic is_access(input sram_state_e st);
    return (st == StData) || (st == StFetch);
  endfunction

endpackage

// File: rtl/sram_fetch_buf.sv
// One-entry fetch buffer {valid, addr, data}. Only built when SRAM_FETCH_BUF_EN is defined.
// Filled after every SRAM fetch, invalidated by a store to the buffered address.
`ifdef SRAM_FETCH_BUF_EN
module sram_fetch_buf
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = SramAddrW,
  parameter int unsigned DATA_W = SramDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval,
  input  logic [ADDR_W-1:0] inval_addr
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Entry update: fill takes priority; a matching store drops the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (fill) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr;
      data_q  <= fill_data;
    end else if (inval && (inval_addr == addr_q)) begin
      valid_q <= 1'b0;
    end
  end

  assign hit      = valid_q && (addr_q == lookup_addr);
  assign hit_data = data_q;

endmodule
`endif

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller shared by instruction fetch and data load/store.
// Data access (older instruction) is serviced before fetch; done flags stay sticky
// until the pipeline advances. Optional fetch buffer: define SRAM_FETCH_BUF_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = SramAddrW,
  parameter int unsigned DATA_W      = SramDataW,
  parameter int unsigned ACC_CYCLES  = SramAccCycles,
  parameter int unsigned INIT_CYCLES = SramInitCycles
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_read_done,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              initializing,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              ram_data_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int unsigned CntMax = (ACC_CYCLES > INIT_CYCLES) ? ACC_CYCLES : INIT_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] AccLast  = CntW'(ACC_CYCLES - 1);
  localparam logic [CntW-1:0] InitLast = CntW'(INIT_CYCLES - 1);

  sram_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              inst_done_q, inst_done_d;
  logic              mem_done_q, mem_done_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              data_oe_q, data_oe_d;

  logic              acc_last;
  logic              data_pend;
  logic              fetch_pend;
  logic              advance;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;

  assign acc_last   = (cnt_q == AccLast);
  assign data_pend  = (mem_rd || mem_wr) && !mem_done_q;
  assign fetch_pend = inst_req && !inst_done_q;
  // Same release condition stall_ctrl uses, so both sides agree on when to move on.
  assign advance    = inst_done_q && (!(mem_rd || mem_wr) || mem_done_q);

`ifdef SRAM_FETCH_BUF_EN
  logic buf_fill;
  logic buf_inval;

  assign buf_fill  = (state_q == StFetch) && acc_last;
  assign buf_inval = (state_q == StData) && acc_last && is_wr_q;

  sram_fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(inst_addr),
    .hit        (buf_hit),
    .hit_data   (buf_data),
    .fill       (buf_fill),
    .fill_addr  (addr_q),
    .fill_data  (ram_data_i),
    .inval      (buf_inval),
    .inval_addr (addr_q)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Next-state, access setup, result capture and registered strobe values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    inst_d      = inst_q;
    rdata_d     = rdata_q;
    inst_done_d = inst_done_q;
    mem_done_d  = mem_done_q;

    unique case (state_q)
      StInit: begin
        if (cnt_q == InitLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (data_pend) begin
          state_d = StData;
          cnt_d   = '0;
          is_wr_d = mem_wr;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
        end else if (fetch_pend) begin
          if (buf_hit) begin
            inst_d      = buf_data;
            inst_done_d = 1'b1;
            state_d     = StDone;
          end else begin
            state_d = StFetch;
            cnt_d   = '0;
            is_wr_d = 1'b0;
            addr_d  = inst_addr;
          end
        end
      end
      StData, StFetch: begin
        if (!acc_last) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (state_q == StData) begin
            mem_done_d = 1'b1;
            if (!is_wr_q) rdata_d = ram_data_i;
          end else begin
            inst_done_d = 1'b1;
            inst_d      = ram_data_i;
          end
          // Uses the updated flag so a just-finished fetch is not repeated.
          if (inst_req && !inst_done_d) begin
            state_d = StFetch;
            is_wr_d = 1'b0;
            addr_d  = inst_addr;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (advance) begin
          inst_done_d = 1'b0;
          mem_done_d  = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase

    // Strobes are registered from next-state so the SRAM pins never glitch.
    ce_n_d    = ~is_access(state_d);
    oe_n_d    = ~(is_access(state_d) && !is_wr_d);
    data_oe_d = is_access(state_d) && is_wr_d;
    // WE drops one cycle before the end of a write to give data hold time.
    we_n_d    = ~(is_access(state_d) && is_wr_d && (cnt_d != AccLast));
  end

  // FSM state register and shared cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access registers, result words, sticky flags and SRAM strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      inst_q      <= '0;
      rdata_q     <= '0;
      inst_done_q <= 1'b0;
      mem_done_q  <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      data_oe_q   <= 1'b0;
    end else begin
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      inst_q      <= inst_d;
      rdata_q     <= rdata_d;
      inst_done_q <= inst_done_d;
      mem_done_q  <= mem_done_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign inst           = inst_q;
  assign inst_read_done = inst_done_q;
  assign mem_rdata      = rdata_q;
  assign mem_done       = mem_done_q;
  assign initializing   = (state_q == StInit);
  assign ram_addr       = addr_q;
  assign ram_data_o     = wdata_q;
  assign ram_data_oe    = data_oe_q;
  assign ram_ce_n       = ce_n_q;
  assign ram_oe_n       = oe_n_q;
  assign ram_we_n       = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural SRAM and expectation queues.
module tb_sram_ctrl;

  localparam int AW = 18;
  localparam int DW = 16;
`ifdef SRAM_FETCH_BUF_EN
  localparam int RefetchLat = 1;
  localparam int RefetchCe  = 0;
`else
  localparam int RefetchLat = 3;
  localparam int RefetchCe  = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst;
  logic          inst_read_done;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          initializing;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_o;
  logic [DW-1:0] ram_data_i;
  logic          ram_data_oe;
  logic          ram_ce_n;
  logic          ram_oe_n;
  logic          ram_we_n;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst          (inst),
    .inst_read_done(inst_read_done),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_done      (mem_done),
    .initializing  (initializing),
    .ram_addr      (ram_addr),
    .ram_data_o    (ram_data_o),
    .ram_data_i    (ram_data_i),
    .ram_data_oe   (ram_data_oe),
    .ram_ce_n      (ram_ce_n),
    .ram_oe_n      (ram_oe_n),
    .ram_we_n      (ram_we_n)
  );

  // Behavioural SRAM: unwritten words read as a fixed pattern; 0x10 holds 0xABCD.
  logic [DW-1:0] ram_mem [0:255];
  logic [255:0]  written;
  int            ce_cycles = 0;

  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 16'hABCD;
    return {8'h5A, a};
  endfunction

  assign ram_data_i = (!ram_ce_n && !ram_oe_n)
                    ? (written[ram_addr[7:0]] ? ram_mem[ram_addr[7:0]] : init_word(ram_addr[7:0]))
                    : 16'hDEAD;

  always @(posedge clk) begin
    if (rst) begin
      written <= '0;
    end else if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
      ram_mem[ram_addr[7:0]] <= ram_data_o;
      written[ram_addr[7:0]] <= 1'b1;
    end
    if (!ram_ce_n) ce_cycles <= ce_cycles + 1;
  end

  typedef struct {
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  exp_t inst_sb[$];
  exp_t data_sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic [DW-1:0] d, input int l);
    exp_t e;
    e.data = d;
    e.lat  = l;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    inst_addr = '0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  // Waits for inst_read_done; cyc counts edges from the call.
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      cyc++;
      if (inst_read_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    bit saw_ce;
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe} !== 4'b1110) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 1110",
               {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe});
    end
    total++;
    if ({inst_read_done, mem_done, initializing} !== 3'b001) begin
      bad++;
      $display("FAIL reset_flags: got %b want 001", {inst_read_done, mem_done, initializing});
    end
    total++;
    if (inst !== 16'h0 || mem_rdata !== 16'h0 || ram_addr !== 18'h0) begin
      bad++;
      $display("FAIL reset_regs: got inst=%h rdata=%h addr=%h want 0", inst, mem_rdata, ram_addr);
    end
    rst    = 1'b0;
    n      = 1;  // the release cycle is the first INIT cycle
    saw_ce = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!ram_ce_n) saw_ce = 1'b1;
      if (!initializing) break;
      n++;
    end
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL init_cycles: got %0d want 4", n);
    end
    total++;
    if (saw_ce) begin
      bad++;
      $display("FAIL init_no_access: got ce_n low want none");
    end
  endtask

  task automatic test_fetch();
    int   cyc;
    bit   ok;
    exp_t e;
    inst_addr = 18'h00010;
    inst_req  = 1'b1;
    inst_sb.push_back(mk(init_word(8'h10), 3));
    wait_done(cyc, ok);
    e = inst_sb.pop_front();
    total++;
    if (!ok || cyc != e.lat || inst !== e.data) begin
      bad++;
      $display("FAIL fetch: got ok=%0d lat=%0d inst=%h want lat=%0d inst=%h",
               ok, cyc, inst, e.lat, e.data);
    end
    inst_req = 1'b0;
    step();
    total++;
    if ({inst_read_done, mem_done} !== 2'b00 || inst !== e.data) begin
      bad++;
      $display("FAIL fetch_advance: got flags=%b inst=%h want 00 %h",
               {inst_read_done, mem_done}, inst, e.data);
    end
  endtask

  task automatic test_load_fetch();
    int   cyc;
    bit   ok;
    exp_t e;
    mem_rd    = 1'b1;
    mem_addr  = 18'h00020;
    inst_req  = 1'b1;
    inst_addr = 18'h00040;
    data_sb.push_back(mk(init_word(8'h20), 3));
    inst_sb.push_back(mk(init_word(8'h40), 5));
    for (int k = 1; k <= 2; k++) begin
      step();
      total++;
      if ({ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe, mem_done, ram_addr}
          !== {5'b00100, 18'h00020}) begin
        bad++;
        $display("FAIL load_cycle%0d: got ce/oe/we/doe/done=%b addr=%h want 00100 00020", k,
                 {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe, mem_done}, ram_addr);
      end
    end
    step();
    e = data_sb.pop_front();
    total++;
    if ({mem_done, inst_read_done, ram_oe_n} !== 3'b100 || mem_rdata !== e.data ||
        ram_addr !== 18'h00040) begin
      bad++;
      $display("FAIL load_done: got done/idone/oe=%b rdata=%h addr=%h want 100 %h 00040",
               {mem_done, inst_read_done, ram_oe_n}, mem_rdata, ram_addr, e.data);
    end
    wait_done(cyc, ok);
    e = inst_sb.pop_front();
    total++;
    if (!ok || (cyc + 3) != e.lat || inst !== e.data || mem_done !== 1'b1) begin
      bad++;
      $display("FAIL load_fetch: got ok=%0d lat=%0d inst=%h mem_done=%b want lat=%0d %h 1",
               ok, cyc + 3, inst, mem_done, e.lat, e.data);
    end
    idle_inputs();
    step();
    total++;
    if ({inst_read_done, mem_done} !== 2'b00) begin
      bad++;
      $display("FAIL load_advance: got %b want 00", {inst_read_done, mem_done});
    end
  endtask

  task automatic test_store_fetch();
    int   cyc;
    bit   ok;
    exp_t e;
    mem_wr    = 1'b1;
    mem_addr  = 18'h00030;
    mem_wdata = 16'h1234;
    inst_req  = 1'b1;
    inst_addr = 18'h00050;
    inst_sb.push_back(mk(init_word(8'h50), 5));
    step();
    total++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe} !== 4'b0101 || ram_addr !== 18'h00030 ||
        ram_data_o !== 16'h1234) begin
      bad++;
      $display("FAIL store_cycle1: got ce/oe/we/doe=%b addr=%h data=%h want 0101 00030 1234",
               {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, ram_addr, ram_data_o);
    end
    step();
    total++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe} !== 4'b0111 || ram_addr !== 18'h00030 ||
        ram_data_o !== 16'h1234) begin
      bad++;
      $display("FAIL store_cycle2: got ce/oe/we/doe=%b addr=%h data=%h want 0111 00030 1234",
               {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, ram_addr, ram_data_o);
    end
    step();
    total++;
    if ({mem_done, ram_data_oe, ram_we_n} !== 3'b101 || ram_addr !== 18'h00050) begin
      bad++;
      $display("FAIL store_done: got done/doe/we=%b addr=%h want 101 00050",
               {mem_done, ram_data_oe, ram_we_n}, ram_addr);
    end
    wait_done(cyc, ok);
    e = inst_sb.pop_front();
    total++;
    if (!ok || (cyc + 3) != e.lat || inst !== e.data) begin
      bad++;
      $display("FAIL store_fetch: got ok=%0d lat=%0d inst=%h want lat=%0d %h",
               ok, cyc + 3, inst, e.lat, e.data);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_idle();
    int c0;
    c0 = ce_cycles;
    idle_inputs();
    repeat (5) step();
    total++;
    if (ce_cycles != c0 || {inst_read_done, mem_done, initializing} !== 3'b000) begin
      bad++;
      $display("FAIL idle: got ce_cycles=%0d flags=%b want 0 000",
               ce_cycles - c0, {inst_read_done, mem_done, initializing});
    end
  endtask

  task automatic test_back_to_back();
    int            cyc;
    bit            ok;
    exp_t          e;
    logic [AW-1:0] addrs [3];
    addrs[0] = 18'h00060;
    addrs[1] = 18'h00062;
    addrs[2] = 18'h00064;
    mem_rd   = 1'b1;
    mem_addr = 18'h00030;
    data_sb.push_back(mk(16'h1234, 3));
    for (int i = 0; i < 3; i++) begin
      inst_req  = 1'b1;
      inst_addr = addrs[i];
      inst_sb.push_back(mk(init_word(addrs[i][7:0]), (i == 0) ? 5 : 4));
      wait_done(cyc, ok);
      e = inst_sb.pop_front();
      total++;
      if (!ok || cyc != e.lat || inst !== e.data) begin
        bad++;
        $display("FAIL b2b_fetch%0d: got ok=%0d lat=%0d inst=%h want lat=%0d %h",
                 i, ok, cyc, inst, e.lat, e.data);
      end
      if (i == 0) begin
        e = data_sb.pop_front();
        total++;
        if (mem_done !== 1'b1 || mem_rdata !== e.data) begin
          bad++;
          $display("FAIL b2b_load: got done=%b rdata=%h want 1 %h", mem_done, mem_rdata, e.data);
        end
        mem_rd = 1'b0;
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    inst_req  = 1'b1;
    inst_addr = 18'h00070;
    step();
    step();
    total++;
    if ({ram_ce_n, ram_oe_n} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_access: got ce/oe=%b want 00", {ram_ce_n, ram_oe_n});
    end
    rst = 1'b1;
    step();
    total++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe} !== 4'b1110 ||
        {inst_read_done, mem_done, initializing} !== 3'b001) begin
      bad++;
      $display("FAIL midrst: got strobes=%b flags=%b want 1110 001",
               {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe},
               {inst_read_done, mem_done, initializing});
    end
    rst = 1'b0;
    idle_inputs();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!initializing) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midrst_recover: got initializing=%b want 0", initializing);
    end
  endtask

  task automatic test_fetch_buf();
    int   cyc;
    bit   ok;
    int   c0;
    exp_t e;
    // Prime with an SRAM fetch of 0x10.
    inst_req  = 1'b1;
    inst_addr = 18'h00010;
    inst_sb.push_back(mk(16'hABCD, 3));
    wait_done(cyc, ok);
    e = inst_sb.pop_front();
    total++;
    if (!ok || cyc != e.lat || inst !== e.data) begin
      bad++;
      $display("FAIL buf_prime: got ok=%0d lat=%0d inst=%h want %0d %h", ok, cyc, inst, e.lat,
               e.data);
    end
    inst_req = 1'b0;
    step();
    // Refetch of the same address.
    c0       = ce_cycles;
    inst_req = 1'b1;
    inst_sb.push_back(mk(16'hABCD, RefetchLat));
    wait_done(cyc, ok);
    e = inst_sb.pop_front();
    total++;
    if (!ok || cyc != e.lat || inst !== e.data || (ce_cycles - c0) != RefetchCe) begin
      bad++;
      $display("FAIL buf_refetch: got ok=%0d lat=%0d inst=%h ce=%0d want %0d %h %0d",
               ok, cyc, inst, ce_cycles - c0, e.lat, e.data, RefetchCe);
    end
    inst_req = 1'b0;
    step();
    // Store to the buffered address; the paired fetch must go to the SRAM.
    c0        = ce_cycles;
    mem_wr    = 1'b1;
    mem_addr  = 18'h00010;
    mem_wdata = 16'h5555;
    inst_req  = 1'b1;
    inst_sb.push_back(mk(16'h5555, 5));
    wait_done(cyc, ok);
    e = inst_sb.pop_front();
    total++;
    if (!ok || cyc != e.lat || inst !== e.data || (ce_cycles - c0) != 4 || mem_done !== 1'b1) begin
      bad++;
      $display("FAIL buf_store: got ok=%0d lat=%0d inst=%h ce=%0d done=%b want %0d %h 4 1",
               ok, cyc, inst, ce_cycles - c0, mem_done, e.lat, e.data);
    end
    idle_inputs();
    step();
    // Refetch now sees the stored word.
    c0        = ce_cycles;
    inst_req  = 1'b1;
    inst_addr = 18'h00010;
    inst_sb.push_back(mk(16'h5555, RefetchLat));
    wait_done(cyc, ok);
    e = inst_sb.pop_front();
    total++;
    if (!ok || cyc != e.lat || inst !== e.data || (ce_cycles - c0) != RefetchCe) begin
      bad++;
      $display("FAIL buf_after_store: got ok=%0d lat=%0d inst=%h ce=%0d want %0d %h %0d",
               ok, cyc, inst, ce_cycles - c0, e.lat, e.data, RefetchCe);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_fetch();
    test_load_fetch();
    test_store_fetch();
    test_idle();
    test_back_to_back();
    test_reset_mid_fetch();
    test_fetch_buf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
